// File: rtl/spu_fetch_pkg.sv
// rtl/spu_fetch_pkg.sv - shared state encoding and limits for the SPU operand fetch sequencer
package spu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MEM_LATENCY_MAX = 4;

endpackage

// File: rtl/spu_fetch_addr_gen.sv
// rtl/spu_fetch_addr_gen.sv - loadable wrapping read-address counter, one per operand SRAM
module spu_fetch_addr_gen #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_val,
    input  logic                 inc,
    output logic [ADDR_BITS-1:0] addr
);

    logic [ADDR_BITS-1:0] addr_q;
    logic [ADDR_BITS-1:0] addr_d;

    // Wrap past the top of the SRAM is plain modulo arithmetic.
    always_comb begin
        addr_d = addr_q;
        if (en) begin
            if (load) begin
                addr_d = load_val;
            end else if (inc) begin
                addr_d = addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr = addr_q;

endmodule

// File: rtl/spu_operand_fetch.sv
// rtl/spu_operand_fetch.sv - lockstep two-SRAM operand fetch with latency-compensated aligned output pair
module spu_operand_fetch
    import spu_fetch_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int DATA_BITS   = 8,
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cke,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr0,
    input  logic [ADDR_BITS-1:0] start_addr1,
    input  logic [ADDR_BITS-1:0] length,
    output logic                 busy,
    output logic                 done,
    output logic                 mem0_en,
    output logic [ADDR_BITS-1:0] mem0_addr,
    input  logic [DATA_BITS-1:0] mem0_rdata,
    output logic                 mem1_en,
    output logic [ADDR_BITS-1:0] mem1_addr,
    input  logic [DATA_BITS-1:0] mem1_rdata,
    output logic [DATA_BITS-1:0] m_data0,
    output logic [DATA_BITS-1:0] m_data1,
    output logic                 m_valid
);

    typedef logic [DATA_BITS-1:0] data_t;

    localparam logic [MEM_LATENCY_MAX-1:0] LAT_MASK =
        MEM_LATENCY_MAX'((1 << MEM_LATENCY) - 1);

    state_t                     state_q, state_d;
    logic [ADDR_BITS-1:0]       remain_q, remain_d;
    logic [MEM_LATENCY_MAX-1:0] vpipe_q, vpipe_d;
    logic                       m_valid_q, m_valid_d;
    data_t                      m_data0_q, m_data0_d;
    data_t                      m_data1_q, m_data1_d;

    logic accept;
    logic issue;
    logic tail;

    assign accept = cke && (state_q == IDLE) && start;
    assign issue  = cke && (state_q == RUN);
    assign tail   = vpipe_q[MEM_LATENCY-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cke) begin
            case (state_q)
                IDLE:    if (start) state_d = (length == '0) ? DONE : RUN;
                RUN:     if (remain_q == ADDR_BITS'(1)) state_d = DRAIN;
                DRAIN:   if ((vpipe_q & LAT_MASK) == '0) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = (state_q == RUN) || (state_q == DRAIN);
        done    = (state_q == DONE);
        mem0_en = issue;
        mem1_en = issue;
    end

    // The valid pipe mirrors the SRAM read latency; its tail marks rdata worth capturing.
    always_comb begin
        remain_d  = remain_q;
        vpipe_d   = vpipe_q;
        m_valid_d = m_valid_q;
        m_data0_d = m_data0_q;
        m_data1_d = m_data1_q;
        if (accept) begin
            remain_d = length;
        end else if (issue) begin
            remain_d = remain_q - 1'b1;
        end
        if (cke) begin
            vpipe_d   = {vpipe_q[MEM_LATENCY_MAX-2:0], issue} & LAT_MASK;
            m_valid_d = tail;
            if (tail) begin
                m_data0_d = mem0_rdata;
                m_data1_d = mem1_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remain_q  <= '0;
            vpipe_q   <= '0;
            m_valid_q <= 1'b0;
            m_data0_q <= '0;
            m_data1_q <= '0;
        end else begin
            remain_q  <= remain_d;
            vpipe_q   <= vpipe_d;
            m_valid_q <= m_valid_d;
            m_data0_q <= m_data0_d;
            m_data1_q <= m_data1_d;
        end
    end

    spu_fetch_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_addr0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (cke),
        .load     (accept),
        .load_val (start_addr0),
        .inc      (issue),
        .addr     (mem0_addr)
    );

    spu_fetch_addr_gen #(.ADDR_BITS(ADDR_BITS)) u_addr1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (cke),
        .load     (accept),
        .load_val (start_addr1),
        .inc      (issue),
        .addr     (mem1_addr)
    );

    assign m_valid = m_valid_q;
    assign m_data0 = m_data0_q;
    assign m_data1 = m_data1_q;

endmodule

// File: tb/tb_spu_operand_fetch.sv
// tb/tb_spu_operand_fetch.sv - bench for spu_operand_fetch at read latencies 1 and 3
module tb_spu_operand_fetch;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cke = 1'b0;
    logic       start = 1'b0;
    logic [9:0] start_addr0 = '0;
    logic [9:0] start_addr1 = '0;
    logic [9:0] length = '0;

    logic [1:0] busy, done, en0, en1, mval;
    logic [9:0] addr0 [2];
    logic [9:0] addr1 [2];
    logic [7:0] rd0 [2];
    logic [7:0] rd1 [2];
    logic [7:0] md0 [2];
    logic [7:0] md1 [2];
    logic [7:0] p0 [2][4];
    logic [7:0] p1 [2][4];

    int tests = 0;
    int fails = 0;
    int done_at [2];

    typedef struct {
        int len;
        int a0;
        int a1;
        int mode;      // 0 cke high, 1 cke low in cycles 2-3, 2 random cke + stray starts, 3 stray start in cycle 2
        int exp_d1;    // cycle of done for latency 1, -1 = not tabulated
        int exp_d3;    // cycle of done for latency 3
    } vec_t;

    always #5 clk = ~clk;

    spu_operand_fetch #(.ADDR_BITS(10), .DATA_BITS(8), .MEM_LATENCY(1)) u_l1 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .start(start),
        .start_addr0(start_addr0), .start_addr1(start_addr1), .length(length),
        .busy(busy[0]), .done(done[0]),
        .mem0_en(en0[0]), .mem0_addr(addr0[0]), .mem0_rdata(rd0[0]),
        .mem1_en(en1[0]), .mem1_addr(addr1[0]), .mem1_rdata(rd1[0]),
        .m_data0(md0[0]), .m_data1(md1[0]), .m_valid(mval[0])
    );

    spu_operand_fetch #(.ADDR_BITS(10), .DATA_BITS(8), .MEM_LATENCY(3)) u_l3 (
        .clk(clk), .reset_n(reset_n), .cke(cke), .start(start),
        .start_addr0(start_addr0), .start_addr1(start_addr1), .length(length),
        .busy(busy[1]), .done(done[1]),
        .mem0_en(en0[1]), .mem0_addr(addr0[1]), .mem0_rdata(rd0[1]),
        .mem1_en(en1[1]), .mem1_addr(addr1[1]), .mem1_rdata(rd1[1]),
        .m_data0(md0[1]), .m_data1(md1[1]), .m_valid(mval[1])
    );

    // SRAMs hold data = addr[7:0]; output registers advance only with cke.
    always @(posedge clk) begin
        if (cke) begin
            for (int d = 0; d < 2; d++) begin
                for (int j = 3; j > 0; j--) begin
                    p0[d][j] <= p0[d][j-1];
                    p1[d][j] <= p1[d][j-1];
                end
                p0[d][0] <= en0[d] ? addr0[d][7:0] : 8'hEE;
                p1[d][0] <= en1[d] ? addr1[d][7:0] : 8'hEE;
            end
        end
    end

    assign rd0[0] = p0[0][0];
    assign rd1[0] = p1[0][0];
    assign rd0[1] = p0[1][2];
    assign rd1[1] = p1[1][2];

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lat%0d t=%0t: got %0h expected %0h", name, lat(d), $time, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_busy"}, d, 32'(busy[d]), 0);
            chk({tag, "_done"}, d, 32'(done[d]), 0);
            chk({tag, "_en"}, d, 32'({en0[d], en1[d]}), 0);
            chk({tag, "_valid"}, d, 32'(mval[d]), 0);
            chk({tag, "_addr"}, d, 32'({addr0[d], addr1[d]}), 0);
            chk({tag, "_data"}, d, 32'({md0[d], md1[d]}), 0);
        end
    endtask

    // Expected outputs after e enabled edges since the start edge.
    task automatic check_cycle(input int e, input logic ck, input int len,
                               input logic [9:0] a0, input logic [9:0] a1, input int c);
        for (int d = 0; d < 2; d++) begin
            int   L = lat(d);
            logic eb, ed, ee, ev;
            logic [9:0] ia0, ia1, va0, va1;
            eb = (len != 0) && (e >= 1) && (e <= len + L + 1);
            ed = (len == 0) ? (e == 1) : (e == len + L + 2);
            ee = ck && (e >= 1) && (e <= len);
            ev = (e >= L + 2) && (e <= len + L + 1);
            chk("busy", d, 32'(busy[d]), 32'(eb));
            chk("done", d, 32'(done[d]), 32'(ed));
            chk("mem0_en", d, 32'(en0[d]), 32'(ee));
            chk("mem1_en", d, 32'(en1[d]), 32'(ee));
            chk("m_valid", d, 32'(mval[d]), 32'(ev));
            if (ee) begin
                ia0 = a0 + 10'(e - 1);
                ia1 = a1 + 10'(e - 1);
                chk("mem0_addr", d, 32'(addr0[d]), 32'(ia0));
                chk("mem1_addr", d, 32'(addr1[d]), 32'(ia1));
            end
            if (ev) begin
                va0 = a0 + 10'(e - L - 2);
                va1 = a1 + 10'(e - L - 2);
                chk("m_data0", d, 32'(md0[d]), 32'(va0[7:0]));
                chk("m_data1", d, 32'(md1[d]), 32'(va1[7:0]));
            end
            if (done[d] === 1'b1 && done_at[d] == 0) done_at[d] = c;
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int   e;
        int   c;
        logic ck;
        logic stray;
        done_at[0] = 0;
        done_at[1] = 0;
        start       = 1'b1;
        cke         = 1'b1;
        length      = 10'(v.len);
        start_addr0 = 10'(v.a0);
        start_addr1 = 10'(v.a1);
        @(posedge clk); #1;
        e = 1;
        c = 1;
        start       = 1'b0;
        start_addr0 = 10'($urandom);
        start_addr1 = 10'($urandom);
        length      = 10'($urandom);
        while (e <= v.len + 6 && c < 4000) begin
            case (v.mode)
                1:       ck = !(c == 2 || c == 3);
                2:       ck = ($urandom_range(0, 3) != 0);
                default: ck = 1'b1;
            endcase
            stray = (v.len > 0) && (e <= v.len + 2) &&
                    ((v.mode == 3) ? (c == 2) : (v.mode == 2 && $urandom_range(0, 5) == 0));
            cke   = ck;
            start = stray;
            if (stray) begin
                start_addr0 = 10'($urandom);
                start_addr1 = 10'($urandom);
                length      = 10'($urandom_range(1, 20));
            end
            #1;
            check_cycle(e, ck, v.len, 10'(v.a0), 10'(v.a1), c);
            @(posedge clk); #1;
            if (ck) e++;
            c++;
        end
        start = 1'b0;
        cke   = 1'b1;
        if (c >= 4000) chk("xfer_timeout", 0, 32'(c), 0);
        if (v.exp_d1 >= 0) begin
            chk("done_cycle", 0, 32'(done_at[0]), 32'(v.exp_d1));
            chk("done_cycle", 1, 32'(done_at[1]), 32'(v.exp_d3));
        end
    endtask

    initial begin
        vec_t vecs [6];
        vec_t rv;
        vecs[0] = '{len: 4, a0: 'h010, a1: 'h200, mode: 0, exp_d1: 7,  exp_d3: 9};
        vecs[1] = '{len: 0, a0: 'h055, a1: 'h0AA, mode: 0, exp_d1: 1,  exp_d3: 1};
        vecs[2] = '{len: 4, a0: 'h3FE, a1: 'h3FD, mode: 0, exp_d1: 7,  exp_d3: 9};
        vecs[3] = '{len: 2, a0: 'h123, a1: 'h321, mode: 1, exp_d1: 7,  exp_d3: 9};
        vecs[4] = '{len: 6, a0: 'h040, a1: 'h080, mode: 3, exp_d1: 9,  exp_d3: 11};
        vecs[5] = '{len: 1, a0: 'h3FF, a1: 'h000, mode: 0, exp_d1: 4,  exp_d3: 6};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        cke = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");

        foreach (vecs[i]) run_xfer(vecs[i]);

        for (int i = 0; i < 20; i++) begin
            rv = '{len: $urandom_range(0, 12), a0: $urandom_range(0, 1023),
                   a1: $urandom_range(0, 1023), mode: 2, exp_d1: -1, exp_d3: -1};
            run_xfer(rv);
        end

        // Abort a length-8 transfer in its third cycle.
        start = 1'b1;
        length = 10'd8;
        start_addr0 = 10'h0F3;
        start_addr1 = 10'h1C7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                chk("abort_no_done", d, 32'(done[d]), 0);
                chk("abort_idle_busy", d, 32'(busy[d]), 0);
            end
        end
        rv = '{len: 5, a0: 'h100, a1: 'h2F0, mode: 0, exp_d1: 8, exp_d3: 10};
        run_xfer(rv);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spu_operand_fetch.md
# spu_operand_fetch

Operand fetch sequencer for the SPU datapath. It reads `length` consecutive words from two operand SRAMs in lockstep and presents them as an aligned pair (`m_data0`, `m_data1`) with `m_valid`. The outputs feed the two source operands of the configurable logic/ALU stage directly downstream. The block issues one read per enabled cycle, compensates for SRAM read latency, and signals completion with a single-cycle `done`.

## Interface
- `ADDR_BITS`, 10: SRAM address width; also the width of `length`.
- `DATA_BITS`, 8: operand word width.
- `MEM_LATENCY`, 1: SRAM read latency in enabled cycles; legal range 1..4.
- `data_t`, `logic [DATA_BITS-1:0]`: operand type.

- `clk` input 1: single clock; all logic on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `cke` input 1: global clock enable. When low, all state holds.
- `start` input 1: request a transfer; sampled only in IDLE with `cke`=1.
- `start_addr0` input ADDR_BITS: first address for operand 0.
- `start_addr1` input ADDR_BITS: first address for operand 1.
- `length` input ADDR_BITS: word count; 0 is legal.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle completion pulse.
- `mem0_en` / `mem1_en` output 1: SRAM read enables.
- `mem0_addr` / `mem1_addr` output ADDR_BITS: SRAM read addresses.
- `mem0_rdata` / `mem1_rdata` input data_t: SRAM read data, valid MEM_LATENCY enabled cycles after the matching `en`.
- `m_data0` / `m_data1` output data_t: registered operand pair.
- `m_valid` output 1: operand pair valid.

## Operation
- FSM states and transitions:
  - IDLE: on `start` with `length`≠0, go to RUN. On `start` with `length`=0, go to DONE.
  - RUN: issue one read per enabled cycle. After issue number `length`, go to DRAIN.
  - DRAIN: wait until the valid pipeline is empty, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Register `start_addr*` and `length` when `start` is accepted. Later changes on these inputs have no effect on the running transfer.
- In RUN, `memN_en`=1. `mem0_en` and `mem1_en` are always identical, and both addresses advance together by +1 per issue.
- Addresses wrap modulo 2^ADDR_BITS (for example 0x3FF → 0x000 with default parameters). Wrap-around is not an error.
- A MEM_LATENCY-deep valid shift register tracks in-flight reads. At its tail, capture `memN_rdata` into `m_dataN` and set `m_valid`.
- `cke`=0 freezes the FSM, counters, valid pipe and outputs. `memN_en` is forced to 0 during such cycles. The SRAM output registers are gated by the same `cke`.
- `start` in any state other than IDLE is ignored, with no queuing.
- `busy` is high in RUN and DRAIN. It is low in IDLE and DONE.
- Reset, including mid-transfer: the transfer is aborted, the FSM returns to IDLE, and no `done` pulse is produced. Every output resets to 0: `busy`, `done`, `m_valid`, `memN_en`, `memN_addr`, `m_dataN`.

## Timing
- Counting assumes `cke` is always high. Edge E0 accepts `start`.
- Issue k (k=1..length) occurs in cycle k with `memN_addr` = start_addrN + k−1.
- The pair for issue k has `m_valid`=1 in cycle k+MEM_LATENCY+1. A full-rate transfer therefore produces back-to-back valids with no gaps.
- `busy` is high in cycles 1..length+MEM_LATENCY+1.
- `done` is high in cycle length+MEM_LATENCY+2, with `busy` already low.
- With `length`=0: `done` is high in cycle 1, and there is no `mem_en` and no `m_valid`.
- A new `start` may be accepted in the cycle after `done`.
- `cke` low cycles add exactly one cycle each to all of the above latencies.

## Structure
- Package `spu_fetch_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DRAIN, DONE);
  - the localparam `MEM_LATENCY_MAX` = 4.
- Sub-module `spu_fetch_addr_gen` is a loadable ADDR_BITS counter with enable and wrap, instanced once per memory.

## Test plan
- start_addr0=0x010, start_addr1=0x200, length=4, MEM_LATENCY=1, memories hold data=addr[7:0] → pairs (0x10,0x00) … (0x13,0x03) valid in cycles 3–6; `done` in cycle 7.
- length=0 → `done` in cycle 1; `mem_en` and `m_valid` never assert.
- start_addr0=0x3FE, length=4 → `mem0_addr` sequence 0x3FE, 0x3FF, 0x000, 0x001.
- MEM_LATENCY=3, length=2, `cke` low for 2 cycles after the first issue → data order preserved; `done` in cycle 9.
- Drop `reset_n` in cycle 3 of a length-8 transfer → all outputs 0 immediately; no `done`; a new start then runs cleanly.
- Pulse `start` during RUN with different addresses → ignored; the original transfer completes unchanged.
